beat_sequencer: RTL and testbench

- Parametrised timing-beat generator for the hardwired CPU controller.
- Generalises the fixed three-beat scheme (w1/w2/w3) to NBEAT one-hot beats, with per-cycle short/long length selection driven back by the controller.
- Adds a latched console mode, a phase flag st0, stop handling and a machine-cycle counter.
- Sits between the console switches/start button and the combinational control-signal decoder, which consumes w and st0.

---
 rtl/beat_sequencer.sv | 147 ++++++++++++++
 tb/tb_beat_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// beat_sequencer: one-hot timing-beat generator for the hardwired CPU controller.
// It issues NBEAT one-hot beats per machine cycle. The controller can shorten
// or lengthen each cycle. The block also latches the console mode, keeps the
// st0 phase flag, handles stop requests and counts completed machine cycles.
module beat_sequencer #(
  parameter int NBEAT       = 4,
  parameter int NORM_BEATS  = 2,
  parameter int SHORT_BEATS = 1,
  parameter int CNT_W       = 8
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             swc,
  input  logic             swb,
  input  logic             swa,
  input  logic             qd,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  output logic [NBEAT-1:0] w,
  output logic             st0,
  output logic [2:0]       mode,
  output logic             running,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [NBEAT-1:0] BEAT1 = NBEAT'(1);
  // Bits k >= SHORT_BEATS-1: the beats where a short request may close the cycle.
  localparam logic [NBEAT-1:0] GE_SHORT_MASK = ~((BEAT1 << (SHORT_BEATS - 1)) - BEAT1);

  state_t           state_q, state_d;
  logic [NBEAT-1:0] w_q, w_d;
  logic             st0_q, st0_d;
  logic [2:0]       mode_q, mode_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             stop_pend_q, stop_pend_d;

  logic [2:0]       sw;
  logic             mode_chg;
  logic             end_cyc;

  assign sw       = {swc, swb, swa};
  assign mode_chg = (sw != mode_q);

  // Decide whether the current beat closes the machine cycle. Short beats long, and the last beat always ends the cycle.
  always_comb begin
    end_cyc = w_q[NBEAT-1];
    if (short) begin
      end_cyc = end_cyc | (|(w_q & GE_SHORT_MASK));
    end else if (long) begin
      end_cyc = end_cyc;
    end else begin
      end_cyc = end_cyc | w_q[NORM_BEATS-1];
    end
  end

  // Next-state logic. A mode change outranks end-of-cycle and stop handling.
  always_comb begin
    // NOTE: every target gets a default first, so no path leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    w_d         = w_q;
    st0_d       = st0_q;
    mode_d      = mode_q;
    cyc_cnt_d   = cyc_cnt_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      IDLE: begin
        if (mode_chg) begin
          st0_d  = 1'b0;
          mode_d = sw;
        end
        if (qd) begin
          state_d   = RUN;
          w_d       = BEAT1;
          mode_d    = sw;
          cyc_cnt_d = '0;
        end
      end
      RUN: begin
        if (mode_chg) begin
          state_d     = IDLE;
          w_d         = '0;
          st0_d       = 1'b0;
          stop_pend_d = 1'b0;
          mode_d      = sw;
        end else if (end_cyc) begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
          st0_d     = 1'b1;
          if (stop_pend_q || stop) begin
            state_d     = IDLE;
            w_d         = '0;
            stop_pend_d = 1'b0;
          end else begin
            w_d = BEAT1;
          end
        end else begin
          w_d = w_q << 1;
          if (stop) begin
            stop_pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        w_d     = '0;
      end
    endcase

    running_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge t3) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (!clr) begin
      state_q     <= IDLE;
      w_q         <= '0;
      st0_q       <= 1'b0;
      mode_q      <= 3'b000;
      running_q   <= 1'b0;
      cyc_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      st0_q       <= st0_d;
      mode_q      <= mode_d;
      running_q   <= running_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign w       = w_q;
  assign st0     = st0_q;
  assign mode    = mode_q;
  assign running = running_q;
  assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed bench for beat_sequencer. It uses one default
// instance and one wide instance (NBEAT=6, NORM=3, SHORT=2, CNT_W=2). Both
// instances share the same stimulus.
module tb_beat_sequencer;

  logic t3 = 1'b0;
  logic clr, swc, swb, swa, qd, short, long, stop;

  logic [3:0] w_a;
  logic       st0_a, running_a;
  logic [2:0] mode_a;
  logic [7:0] cnt_a;

  logic [5:0] w_b;
  logic       st0_b, running_b;
  logic [2:0] mode_b;
  logic [1:0] cnt_b;

  int tests  = 0;
  int errors = 0;

  always #5 t3 = ~t3;

  beat_sequencer dut_a (
    .t3(t3), .clr(clr), .swc(swc), .swb(swb), .swa(swa), .qd(qd),
    .short(short), .long(long), .stop(stop),
    .w(w_a), .st0(st0_a), .mode(mode_a), .running(running_a), .cyc_cnt(cnt_a)
  );

  beat_sequencer #(.NBEAT(6), .NORM_BEATS(3), .SHORT_BEATS(2), .CNT_W(2)) dut_b (
    .t3(t3), .clr(clr), .swc(swc), .swb(swb), .swa(swa), .qd(qd),
    .short(short), .long(long), .stop(stop),
    .w(w_b), .st0(st0_b), .mode(mode_b), .running(running_b), .cyc_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge t3);
    #1;
  endtask

  // Check all outputs of the default instance.
  task automatic chk_a(input string tag, input logic [3:0] ew, input logic est0,
                       input logic erun, input logic [7:0] ecnt);
    check({tag, ".w"}, 32'(w_a), 32'(ew));
    check({tag, ".st0"}, 32'(st0_a), 32'(est0));
    check({tag, ".run"}, 32'(running_a), 32'(erun));
    check({tag, ".cnt"}, 32'(cnt_a), 32'(ecnt));
  endtask

  logic [3:0] seq_w   [6];
  logic [7:0] seq_cnt [6];
  logic [5:0] b_w     [12];
  logic [1:0] b_cnt   [12];

  initial begin
    clr = 1'b0; {swc, swb, swa} = 3'b000; qd = 1'b0;
    short = 1'b0; long = 1'b0; stop = 1'b0;
    tick(); tick();
    chk_a("rst", 4'b0000, 1'b0, 1'b0, 8'd0);
    check("rst.mode", 32'(mode_a), 32'd0);
    clr = 1'b1;
    tick(); tick();
    chk_a("idle_noqd", 4'b0000, 1'b0, 1'b0, 8'd0);

    // Normal two-beat cycles with a one-cycle qd pulse.
    qd = 1'b1; tick(); qd = 1'b0;
    chk_a("start", 4'b0001, 1'b0, 1'b1, 8'd0);
    seq_w   = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    seq_cnt = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_a($sformatf("norm%0d", i), seq_w[i], (i >= 1), 1'b1, seq_cnt[i]);
    end

    // Long cycle: four beats.
    long = 1'b1;
    tick(); chk_a("long1", 4'b0010, 1'b1, 1'b1, 8'd3);
    tick(); chk_a("long2", 4'b0100, 1'b1, 1'b1, 8'd3);
    tick(); chk_a("long3", 4'b1000, 1'b1, 1'b1, 8'd3);
    tick(); chk_a("long4", 4'b0001, 1'b1, 1'b1, 8'd4);
    // Short cycle ends on beat 1. With short and long both set, short wins.
    long = 1'b0; short = 1'b1;
    tick(); chk_a("short", 4'b0001, 1'b1, 1'b1, 8'd5);
    long = 1'b1;
    tick(); chk_a("shortlong", 4'b0001, 1'b1, 1'b1, 8'd6);
    short = 1'b0;

    // A stop on beat 1 of a long cycle lets the cycle finish.
    stop = 1'b1;
    tick(); chk_a("stop1", 4'b0010, 1'b1, 1'b1, 8'd6);
    stop = 1'b0;
    tick(); chk_a("stop2", 4'b0100, 1'b1, 1'b1, 8'd6);
    tick(); chk_a("stop3", 4'b1000, 1'b1, 1'b1, 8'd6);
    tick(); chk_a("stop4", 4'b0000, 1'b1, 1'b0, 8'd7);
    tick(); chk_a("stop_hold", 4'b0000, 1'b1, 1'b0, 8'd7);
    long = 1'b0;

    // A mode change in IDLE clears st0 and relatches the mode.
    swa = 1'b1;
    tick(); chk_a("mode_idle", 4'b0000, 1'b0, 1'b0, 8'd7);
    check("mode_idle.mode", 32'(mode_a), 32'd1);
    qd = 1'b1; tick(); qd = 1'b0;
    chk_a("m1_start", 4'b0001, 1'b0, 1'b1, 8'd0);
    tick(); tick(); tick();
    chk_a("m1_b2", 4'b0010, 1'b1, 1'b1, 8'd1);
    // A mode change in RUN aborts the cycle.
    {swc, swb, swa} = 3'b100;
    tick(); chk_a("abort", 4'b0000, 1'b0, 1'b0, 8'd1);
    check("abort.mode", 32'(mode_a), 32'd4);
    qd = 1'b1;
    tick(); chk_a("restart", 4'b0001, 1'b0, 1'b1, 8'd0);

    // With qd held, a stop returns to IDLE for one cycle, then the sequencer restarts.
    stop = 1'b1;
    tick(); chk_a("qstop1", 4'b0010, 1'b0, 1'b1, 8'd0);
    stop = 1'b0;
    tick(); chk_a("qstop_idle", 4'b0000, 1'b1, 1'b0, 8'd1);
    tick(); chk_a("qstop_re", 4'b0001, 1'b1, 1'b1, 8'd0);
    qd = 1'b0;
    // A stop on the ending beat halts at once. A stop in IDLE is ignored.
    tick();
    stop = 1'b1;
    tick(); chk_a("stop_end", 4'b0000, 1'b1, 1'b0, 8'd1);
    tick(); chk_a("stop_idle", 4'b0000, 1'b1, 1'b0, 8'd1);
    stop = 1'b0;

    // A reset asserted mid-cycle overrides everything.
    {swc, swb, swa} = 3'b000;
    qd = 1'b1; tick(); qd = 1'b0;
    tick(); chk_a("pre_rst", 4'b0010, 1'b0, 1'b1, 8'd0);
    clr = 1'b0;
    tick(); chk_a("mid_rst", 4'b0000, 1'b0, 1'b0, 8'd0);
    clr = 1'b1;
    tick(); tick(); chk_a("post_rst", 4'b0000, 1'b0, 1'b0, 8'd0);

    // Wide instance: 3-beat normal cycle and 2-bit counter wrap.
    qd = 1'b1; tick(); qd = 1'b0;
    check("b_start.w", 32'(w_b), 32'h01);
    check("b_start.cnt", 32'(cnt_b), 32'd0);
    b_w   = '{6'h02, 6'h04, 6'h01, 6'h02, 6'h04, 6'h01,
              6'h02, 6'h04, 6'h01, 6'h02, 6'h04, 6'h01};
    b_cnt = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
              2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("b_norm%0d.w", i), 32'(w_b), 32'(b_w[i]));
      check($sformatf("b_norm%0d.cnt", i), 32'(cnt_b), 32'(b_cnt[i]));
    end
    // Short cycle: two beats.
    short = 1'b1;
    tick(); check("b_short1.w", 32'(w_b), 32'h02);
    tick(); check("b_short2.w", 32'(w_b), 32'h01);
    check("b_short2.cnt", 32'(cnt_b), 32'd1);
    // Long cycle: six beats.
    short = 1'b0; long = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick(); check($sformatf("b_long%0d.w", i), 32'(w_b), 32'(1 << i));
    end
    tick(); check("b_long_end.w", 32'(w_b), 32'h01);
    check("b_long_end.cnt", 32'(cnt_b), 32'd2);
    long = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
